pid_integrator: RTL and testbench

//  Parametrised integral-term generator for the PID controller; successor to the fixed 10b-in/9b-out integrator.

---
 rtl/pid_integrator.sv | 126 ++++++++++++
 tb/tb_pid_integrator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pid_integrator.sv
// pid_integrator: integral-term generator for the PID controller.
// Accumulates signed error samples into an ACC_W-bit accumulator and
// presents its top OUT_W bits as I_term. The accumulator can freeze or
// clamp on overflow, and samples can be decimated by INTEG_DIV. It also
// supports external hold/clear, a sticky overflow flag and an update strobe.
// Optional feature: define PID_INTEG_LEAK_EN to add a leak term of
// acc >>> LEAK_SHIFT that is subtracted on every update.
module pid_integrator #(
  parameter int ERR_W      = 10,
  parameter int ACC_W      = 15,
  parameter int OUT_W      = 9,
  parameter int INTEG_DIV  = 1,
  parameter int LEAK_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    moving,
  input  logic                    clr,
  input  logic                    frz,
  input  logic                    sat_mode,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] err_sat,
  output logic signed [OUT_W-1:0] I_term,
  output logic                    I_vld,
  output logic                    ovfl
);

  // Decimation counter is at least one bit wide so INTEG_DIV=1 stays legal.
  localparam int CNT_W = (INTEG_DIV > 1) ? $clog2(INTEG_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTEG_DIV - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

`ifdef PID_INTEG_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  // Overflow of an ACC_W+1-bit sum: the two top bits disagree.
  function automatic logic sum_ovf(input logic signed [ACC_W:0] sum);
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  endfunction

  // Next accumulator value. Pass through when in range. On overflow either
  // hold the old value (legacy freeze) or snap to the rail that the sum's
  // sign points at (clamp).
  function automatic logic signed [ACC_W-1:0] sat_acc(
    input logic signed [ACC_W:0]   sum,
    input logic                    clamp,
    input logic signed [ACC_W-1:0] acc_hold
  );
    if (!sum_ovf(sum)) begin
      sat_acc = sum[ACC_W-1:0];
    end else if (clamp) begin
      sat_acc = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_acc = acc_hold;
    end
  endfunction

  logic signed [ACC_W-1:0] r_acc_p0;
  logic [CNT_W-1:0]        r_div_cnt;
  logic                    r_vld_p0;
  logic                    r_ovfl;

  logic                    w_clear;
  logic                    w_last;
  logic signed [ACC_W:0]   w_acc_ext;
  logic signed [ACC_W:0]   w_err_ext;
  logic signed [ACC_W-1:0] w_leak;
  logic signed [ACC_W:0]   w_leak_ext;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_acc_nxt;

  assign w_clear = !moving | clr;
  assign w_last  = (r_div_cnt == CNT_LAST);

  // Widen by one bit so the sum can never wrap before overflow is judged.
  assign w_acc_ext  = (ACC_W+1)'(r_acc_p0);
  assign w_err_ext  = (ACC_W+1)'(err_sat);
  assign w_leak     = LEAK_ON ? (r_acc_p0 >>> LEAK_SHIFT) : '0;
  assign w_leak_ext = (ACC_W+1)'(w_leak);
  assign w_sum      = w_acc_ext + w_err_ext - w_leak_ext;
  assign w_ovf      = sum_ovf(w_sum);
  assign w_acc_nxt  = sat_acc(w_sum, sat_mode, r_acc_p0);

  // ---- stage p0: accumulator, decimation counter, strobe, sticky flag ----
  // Clear beats hold, and hold beats sample processing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_p0  <= '0;
      r_div_cnt <= '0;
      r_vld_p0  <= 1'b0;
      r_ovfl    <= 1'b0;
    end else if (w_clear) begin
      r_acc_p0  <= '0;
      r_div_cnt <= '0;
      r_vld_p0  <= 1'b0;
      r_ovfl    <= 1'b0;
    end else if (frz) begin
      r_vld_p0  <= 1'b0;
    end else if (err_vld) begin
      if (w_last) begin
        r_div_cnt <= '0;
        r_acc_p0  <= w_acc_nxt;
        r_vld_p0  <= 1'b1;
        if (w_ovf) begin
          r_ovfl <= 1'b1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + CNT_W'(1);
        r_vld_p0  <= 1'b0;
      end
    end else begin
      r_vld_p0  <= 1'b0;
    end
  end

  assign I_term = r_acc_p0[ACC_W-1 -: OUT_W];
  assign I_vld  = r_vld_p0;
  assign ovfl   = r_ovfl;

endmodule

// File: tb/tb_pid_integrator.sv
// Directed bench for pid_integrator: a default instance (INTEG_DIV=1) and a
// decimating instance (INTEG_DIV=4) driven from the same stimulus.
module tb_pid_integrator;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              moving;
  logic              clr;
  logic              frz;
  logic              sat_mode;
  logic              err_vld;
  logic signed [9:0] err_sat;
  logic signed [8:0] I_term;
  logic              I_vld;
  logic              ovfl;
  logic signed [8:0] I_term4;
  logic              I_vld4;
  logic              ovfl4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pid_integrator dut (
    .clk(clk), .rst_n(rst_n), .moving(moving), .clr(clr), .frz(frz),
    .sat_mode(sat_mode), .err_vld(err_vld), .err_sat(err_sat),
    .I_term(I_term), .I_vld(I_vld), .ovfl(ovfl)
  );

  pid_integrator #(.INTEG_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .moving(moving), .clr(clr), .frz(frz),
    .sat_mode(sat_mode), .err_vld(err_vld), .err_sat(err_sat),
    .I_term(I_term4), .I_vld(I_vld4), .ovfl(ovfl4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_both();
    clr = 1'b1; err_vld = 1'b0; frz = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; moving = 1'b1; clr = 1'b0; frz = 1'b0; sat_mode = 1'b0;
    err_vld = 1'b1; err_sat = 10'sh0FF;
    repeat (3) tick();
    checks++; if (I_term !== 9'h000) begin errors++; $display("FAIL reset_iterm got %h exp 000", I_term); end
    checks++; if (I_vld !== 1'b0) begin errors++; $display("FAIL reset_ivld got %b exp 0", I_vld); end
    checks++; if (ovfl !== 1'b0) begin errors++; $display("FAIL reset_ovfl got %b exp 0", ovfl); end
    rst_n = 1'b1;
  endtask

  // 10 samples of 255: I_term = floor(255*k/64), finishing at 0x027.
  task automatic test_accumulate();
    int exp_t;
    err_vld = 1'b1; err_sat = 10'sh0FF;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_t = (255 * k) / 64;
      checks++; if (I_term !== 9'(exp_t)) begin errors++; $display("FAIL acc_iterm k=%0d got %h exp %h", k, I_term, 9'(exp_t)); end
      checks++; if (I_vld !== 1'b1) begin errors++; $display("FAIL acc_ivld k=%0d got %b exp 1", k, I_vld); end
    end
    checks++; if (I_term !== 9'h027) begin errors++; $display("FAIL acc_final got %h exp 027", I_term); end
  endtask

  task automatic test_hold();
    err_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (I_term !== 9'h027 || I_vld !== 1'b0) begin errors++; $display("FAIL idle_hold k=%0d got %h/%b exp 027/0", k, I_term, I_vld); end
    end
    frz = 1'b1; err_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (I_term !== 9'h027 || I_vld !== 1'b0) begin errors++; $display("FAIL frz_hold k=%0d got %h/%b exp 027/0", k, I_term, I_vld); end
    end
    frz = 1'b0; err_vld = 1'b0;
  endtask

  task automatic test_clear();
    moving = 1'b0;
    tick();
    moving = 1'b1;
    checks++; if (I_term !== 9'h000 || ovfl !== 1'b0 || I_vld !== 1'b0) begin errors++; $display("FAIL clr_moving got %h/%b/%b exp 000/0/0", I_term, ovfl, I_vld); end
    err_vld = 1'b1; err_sat = 10'sh0FF;
    repeat (2) tick();
    checks++; if (I_term !== 9'h007) begin errors++; $display("FAIL clr_reacc got %h exp 007", I_term); end
    // clr must win over frz and over a valid sample on the same edge
    clr = 1'b1; frz = 1'b1;
    tick();
    clr = 1'b0; frz = 1'b0; err_vld = 1'b0;
    checks++; if (I_term !== 9'h000 || I_vld !== 1'b0) begin errors++; $display("FAIL clr_prio got %h/%b exp 000/0", I_term, I_vld); end
  endtask

  // +511 x40, then a -33 sample that separates freeze (16352) from clamp (16383).
  task automatic test_ovfl_pos(input logic mode, input logic [8:0] exp_after);
    int exp_t;
    sat_mode = mode; err_vld = 1'b1; err_sat = 10'sh1FF;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_t = (k <= 32) ? (511 * k) / 64 : 255;
      checks++; if (I_term !== 9'(exp_t)) begin errors++; $display("FAIL ovp_iterm m=%0b k=%0d got %h exp %h", mode, k, I_term, 9'(exp_t)); end
      checks++; if (ovfl !== (k >= 33)) begin errors++; $display("FAIL ovp_flag m=%0b k=%0d got %b exp %b", mode, k, ovfl, (k >= 33)); end
      checks++; if (I_vld !== 1'b1) begin errors++; $display("FAIL ovp_ivld m=%0b k=%0d got %b exp 1", mode, k, I_vld); end
    end
    err_sat = -10'sd33;
    tick();
    checks++; if (I_term !== exp_after || ovfl !== 1'b1) begin errors++; $display("FAIL ovp_back m=%0b got %h/%b exp %h/1", mode, I_term, ovfl, exp_after); end
    clear_both();
    checks++; if (ovfl !== 1'b0 || I_term !== 9'h000) begin errors++; $display("FAIL ovp_clr m=%0b got %h/%b exp 000/0", mode, I_term, ovfl); end
  endtask

  task automatic test_ovfl_neg();
    int exp_t;
    sat_mode = 1'b1; err_vld = 1'b1; err_sat = -10'sd512;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_t = (k <= 32) ? -8 * k : -256;
      checks++; if (I_term !== 9'(exp_t)) begin errors++; $display("FAIL ovn_iterm k=%0d got %h exp %h", k, I_term, 9'(exp_t)); end
      checks++; if (ovfl !== (k >= 33)) begin errors++; $display("FAIL ovn_flag k=%0d got %b exp %b", k, ovfl, (k >= 33)); end
    end
    checks++; if (I_term !== 9'h100) begin errors++; $display("FAIL ovn_final got %h exp 100", I_term); end
    clear_both();
    sat_mode = 1'b0;
  endtask

  task automatic test_leak();
    int a;
    int s;
    int exp_t;
    sat_mode = 1'b0; err_vld = 1'b1; err_sat = 10'sh1FF;
    repeat (33) tick();
    err_sat = 10'sh000;
    tick();
`ifdef PID_INTEG_LEAK_EN
    a = 0;
    for (int k = 0; k < 33; k++) begin
      s = a + 511 - (a >>> 8);
      if (s <= 16383) a = s;
    end
    a = a - (a >>> 8);
    exp_t = a >>> 6;
`else
    a = 16352; s = 0;
    exp_t = a / 64;
`endif
    checks++; if (I_term !== 9'(exp_t) || I_vld !== 1'b1) begin errors++; $display("FAIL leak_step got %h/%b exp %h/1", I_term, I_vld, 9'(exp_t)); end
    clear_both();
  endtask

  task automatic test_decimate();
    logic [8:0] exp_t;
    clear_both();
    err_vld = 1'b1; err_sat = 10'sh0FF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_t = (k < 4) ? 9'd0 : ((k < 8) ? 9'd3 : 9'd7);
      checks++; if (I_vld4 !== (k % 4 == 0)) begin errors++; $display("FAIL div_ivld k=%0d got %b exp %b", k, I_vld4, (k % 4 == 0)); end
      checks++; if (I_term4 !== exp_t) begin errors++; $display("FAIL div_iterm k=%0d got %h exp %h", k, I_term4, exp_t); end
    end
    // Counter must not advance on idle or frozen cycles.
    clear_both();
    err_vld = 1'b1;
    repeat (3) tick();
    err_vld = 1'b0;
    repeat (2) tick();
    frz = 1'b1; err_vld = 1'b1;
    repeat (2) tick();
    checks++; if (I_vld4 !== 1'b0 || I_term4 !== 9'h000) begin errors++; $display("FAIL div_hold got %b/%h exp 0/000", I_vld4, I_term4); end
    frz = 1'b0;
    tick();
    checks++; if (I_vld4 !== 1'b1 || I_term4 !== 9'h003) begin errors++; $display("FAIL div_resume got %b/%h exp 1/003", I_vld4, I_term4); end
    clear_both();
  endtask

  task automatic test_async_reset();
    sat_mode = 1'b0; err_vld = 1'b1; err_sat = 10'sh1FF;
    repeat (34) tick();
    checks++; if (ovfl !== 1'b1) begin errors++; $display("FAIL ares_pre got %b exp 1", ovfl); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (I_term !== 9'h000 || I_vld !== 1'b0 || ovfl !== 1'b0) begin errors++; $display("FAIL ares_now got %h/%b/%b exp 000/0/0", I_term, I_vld, ovfl); end
    tick();
    rst_n = 1'b1; err_vld = 1'b0;
    tick();
    checks++; if (I_term !== 9'h000 || ovfl !== 1'b0) begin errors++; $display("FAIL ares_after got %h/%b exp 000/0", I_term, ovfl); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_hold();
    test_clear();
    test_ovfl_pos(1'b0, 9'h0FE);
    test_ovfl_pos(1'b1, 9'h0FF);
    test_ovfl_neg();
    test_leak();
    test_decimate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
